// File: rtl/lib_decmps_to_pow2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lib_decmps_to_pow2_pipe
// Description : Pipelined, flow-controlled decomposer that splits a vector
//               into up to FFS_NUM one-hot vectors (one per set bit) in
//               priority order, under a per-transaction extraction limit.
//               Reports the extracted count and whether bits were left over.
// Revision    : 1.0 - initial release
// ============================================================================
module lib_decmps_to_pow2_pipe #(
  parameter int LSB_MSB        = 0,
  parameter int WIDTH          = 16,
  parameter int FFS_NUM        = 8,
  parameter int FFS_PER_STAGE  = 2,
  localparam int STAGE_NUM     = (FFS_NUM + FFS_PER_STAGE - 1) / FFS_PER_STAGE,
  localparam int CNT_W         = $clog2(FFS_NUM + 1)
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [WIDTH-1:0]                s_vect,
  input  logic [CNT_W-1:0]                s_lim,
  input  logic                            s_vld,
  output logic                            s_rdy,
  output logic [FFS_NUM-1:0][WIDTH-1:0]   m_onehot,
  output logic [CNT_W-1:0]                m_cnt,
  output logic                            m_ovf,
  output logic                            m_vld,
  input  logic                            m_rdy
);

  // Isolate the lowest set bit of a vector.
  function automatic logic [WIDTH-1:0] f_lowest(input logic [WIDTH-1:0] v);
    f_lowest = v & (~v + WIDTH'(1));
  endfunction

  // Priority bit in the configured extraction order; MSB-first reuses the
  // lowest-bit isolation on the bit-reversed vector.
  function automatic logic [WIDTH-1:0] f_prio(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] v_rev;
    logic [WIDTH-1:0] v_sel;
    v_rev = {<<{v}};
    v_sel = f_lowest(v_rev);
    if (LSB_MSB != 0) begin
      f_prio = {<<{v_sel}};
    end else begin
      f_prio = f_lowest(v);
    end
  endfunction

  // Published stage registers, indexed by stage.
  logic [STAGE_NUM-1:0]                            w_vld_bus;
  logic [STAGE_NUM-1:0][WIDTH-1:0]                 w_vec_bus;
  logic [STAGE_NUM-1:0][CNT_W-1:0]                 w_cnt_bus;
  logic [STAGE_NUM-1:0][FFS_NUM-1:0][WIDTH-1:0]    w_slots_bus;
  // Saturated limit as seen at the input of each stage.
  logic [STAGE_NUM-1:0][CNT_W-1:0]                 w_lim_pass;
  logic [STAGE_NUM-1:0]                            w_rdy;

  // Limits above FFS_NUM behave exactly like FFS_NUM.
  assign w_lim_pass[0] = (s_lim > CNT_W'(FFS_NUM)) ? CNT_W'(FFS_NUM) : s_lim;

  for (genvar k = 0; k < STAGE_NUM; k++) begin : g_stage
    localparam int J_LO = k * FFS_PER_STAGE;
    localparam int J_HI = ((k + 1) * FFS_PER_STAGE > FFS_NUM) ? FFS_NUM
                                                              : (k + 1) * FFS_PER_STAGE;

    logic                          w_vld_i;
    logic [WIDTH-1:0]              w_vec_i;
    logic [WIDTH-1:0]              w_vec_o;
    logic [CNT_W-1:0]              w_lim_i;
    logic [CNT_W-1:0]              w_cnt_i;
    logic [CNT_W-1:0]              w_cnt_o;
    logic [FFS_NUM-1:0][WIDTH-1:0] w_slots_i;
    logic [FFS_NUM-1:0][WIDTH-1:0] w_slots_o;

    logic                          r_vld;
    logic [WIDTH-1:0]              r_vec;
    logic [CNT_W-1:0]              r_cnt;
    logic [FFS_NUM-1:0][WIDTH-1:0] r_slots;

    // A stage can load when it is empty or everything downstream can move;
    // equivalent to the ~vld_k | rdy_(k+1) chain, flattened per stage.
    assign w_rdy[k] = m_rdy | ~(&w_vld_bus[STAGE_NUM-1:k]);

    if (k == 0) begin : g_src_in
      assign w_vld_i   = s_vld;
      assign w_vec_i   = s_vect;
      assign w_cnt_i   = '0;
      assign w_slots_i = '0;
    end else begin : g_src_prev
      assign w_vld_i   = w_vld_bus[k-1];
      assign w_vec_i   = w_vec_bus[k-1];
      assign w_cnt_i   = w_cnt_bus[k-1];
      assign w_slots_i = w_slots_bus[k-1];
    end
    assign w_lim_i = w_lim_pass[k];

    // Chain of find-first-set units owned by this stage. The remaining
    // limit is lim - count, so a unit extracts while count < lim.
    for (genvar j = J_LO; j < J_HI; j++) begin : g_unit
      logic [WIDTH-1:0] w_vec_in;
      logic [WIDTH-1:0] w_vec_out;
      logic [WIDTH-1:0] w_bit;
      logic [CNT_W-1:0] w_cnt_in;
      logic [CNT_W-1:0] w_cnt_out;
      logic             w_take;

      if (j == J_LO) begin : g_first
        assign w_vec_in = w_vec_i;
        assign w_cnt_in = w_cnt_i;
      end else begin : g_chain
        assign w_vec_in = g_unit[j-1].w_vec_out;
        assign w_cnt_in = g_unit[j-1].w_cnt_out;
      end

      assign w_take       = (w_cnt_in < w_lim_i) && (w_vec_in != '0);
      assign w_bit        = w_take ? f_prio(w_vec_in) : '0;
      assign w_vec_out    = w_vec_in ^ w_bit;
      assign w_cnt_out    = w_take ? (w_cnt_in + CNT_W'(1)) : w_cnt_in;
      assign w_slots_o[j] = w_bit;
    end

    // Slots owned by other stages pass through untouched.
    for (genvar s = 0; s < FFS_NUM; s++) begin : g_slot
      if ((s < J_LO) || (s >= J_HI)) begin : g_keep
        assign w_slots_o[s] = w_slots_i[s];
      end
    end

    assign w_vec_o = g_unit[J_HI-1].w_vec_out;
    assign w_cnt_o = g_unit[J_HI-1].w_cnt_out;

    // Stage register: loads when ready, holds everything while stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_vld   <= 1'b0;
        r_vec   <= '0;
        r_cnt   <= '0;
        r_slots <= '0;
      end else if (w_rdy[k]) begin
        r_vld <= w_vld_i;
        if (w_vld_i) begin
          r_vec   <= w_vec_o;
          r_cnt   <= w_cnt_o;
          r_slots <= w_slots_o;
        end
      end
    end

    // The limit only needs to travel to stages that still extract.
    if (k < STAGE_NUM - 1) begin : g_lim_fwd
      logic [CNT_W-1:0] r_lim;

      // Limit register, moving in lockstep with the stage data.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_lim <= '0;
        end else if (w_rdy[k] && w_vld_i) begin
          r_lim <= w_lim_i;
        end
      end

      assign w_lim_pass[k+1] = r_lim;
    end

    assign w_vld_bus[k]   = r_vld;
    assign w_vec_bus[k]   = r_vec;
    assign w_cnt_bus[k]   = r_cnt;
    assign w_slots_bus[k] = r_slots;
  end

  assign s_rdy    = w_rdy[0];
  assign m_vld    = w_vld_bus[STAGE_NUM-1];
  assign m_onehot = w_slots_bus[STAGE_NUM-1];
  assign m_cnt    = w_cnt_bus[STAGE_NUM-1];
  assign m_ovf    = |w_vec_bus[STAGE_NUM-1];

endmodule
`default_nettype wire

// File: tb/tb_lib_decmps_to_pow2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lib_decmps_to_pow2_pipe
// Description : Self-checking bench for lib_decmps_to_pow2_pipe. Two
//               instances (LSB-first / 2 units per stage and MSB-first /
//               3 units per stage, both two stages deep) share stimulus and
//               are each scored against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lib_decmps_to_pow2_pipe;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [31:0] oh;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  logic                clk = 1'b0;
  logic                aresetn = 1'b0;
  logic [W-1:0]        s_vect = '0;
  logic [CW-1:0]       s_lim = '0;
  logic                s_vld = 1'b0;
  logic                m_rdy = 1'b1;

  logic                a_srdy, a_ovf, a_mvld;
  logic [N-1:0][W-1:0] a_oh;
  logic [CW-1:0]       a_cnt;
  logic                b_srdy, b_ovf, b_mvld;
  logic [N-1:0][W-1:0] b_oh;
  logic [CW-1:0]       b_cnt;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   sb_en = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  int   pop_cyc[$];
  bit   stall_a = 1'b0, stall_b = 1'b0;
  logic [36:0] prev_a, prev_b;

  always #5 clk = ~clk;

  lib_decmps_to_pow2_pipe #(
    .LSB_MSB(0), .WIDTH(W), .FFS_NUM(N), .FFS_PER_STAGE(2)
  ) u_dut_lsb (
    .aclk(clk), .aresetn(aresetn), .s_vect(s_vect), .s_lim(s_lim),
    .s_vld(s_vld), .s_rdy(a_srdy), .m_onehot(a_oh), .m_cnt(a_cnt),
    .m_ovf(a_ovf), .m_vld(a_mvld), .m_rdy(m_rdy)
  );

  lib_decmps_to_pow2_pipe #(
    .LSB_MSB(1), .WIDTH(W), .FFS_NUM(N), .FFS_PER_STAGE(3)
  ) u_dut_msb (
    .aclk(clk), .aresetn(aresetn), .s_vect(s_vect), .s_lim(s_lim),
    .s_vld(s_vld), .s_rdy(b_srdy), .m_onehot(b_oh), .m_cnt(b_cnt),
    .m_ovf(b_ovf), .m_vld(b_mvld), .m_rdy(m_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk bit positions in extraction order, take set bits until
  // the (saturated) limit is reached; any further set bit means overflow.
  function automatic exp_t f_model(input logic [7:0] v, input logic [2:0] lim, input bit msb);
    exp_t e;
    int   l;
    int   n;
    int   pos;
    e = '0;
    l = (int'(lim) > N) ? N : int'(lim);
    n = 0;
    for (int i = 0; i < W; i++) begin
      pos = msb ? (W - 1 - i) : i;
      if (((v >> pos) & 8'h01) != 8'h00) begin
        if (n < l) begin
          e.oh = e.oh | (32'(1) << (n * 8 + pos));
          n++;
        end else begin
          e.ovf = 1'b1;
        end
      end
    end
    e.cnt = 3'(n);
    return e;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_en && aresetn) begin
        if (s_vld && a_srdy) qa.push_back(f_model(s_vect, s_lim, 1'b0));
        if (s_vld && b_srdy) qb.push_back(f_model(s_vect, s_lim, 1'b1));
        if (stall_a) chk("a_hold", 64'({a_mvld, a_oh, a_cnt, a_ovf}), 64'(prev_a));
        if (stall_b) chk("b_hold", 64'({b_mvld, b_oh, b_cnt, b_ovf}), 64'(prev_b));
        if (a_mvld && m_rdy) begin
          pop_cyc.push_back(cyc);
          if (qa.size() == 0) begin
            chk("a_unexpected_out", 64'(a_mvld), 64'(0));
          end else begin
            e = qa.pop_front();
            chk("a_onehot", 64'(a_oh), 64'(e.oh));
            chk("a_cnt", 64'(a_cnt), 64'(e.cnt));
            chk("a_ovf", 64'(a_ovf), 64'(e.ovf));
          end
        end
        if (b_mvld && m_rdy) begin
          if (qb.size() == 0) begin
            chk("b_unexpected_out", 64'(b_mvld), 64'(0));
          end else begin
            e = qb.pop_front();
            chk("b_onehot", 64'(b_oh), 64'(e.oh));
            chk("b_cnt", 64'(b_cnt), 64'(e.cnt));
            chk("b_ovf", 64'(b_ovf), 64'(e.ovf));
          end
        end
        stall_a = a_mvld && !m_rdy;
        stall_b = b_mvld && !m_rdy;
        prev_a  = {a_mvld, a_oh, a_cnt, a_ovf};
        prev_b  = {b_mvld, b_oh, b_cnt, b_ovf};
      end else begin
        stall_a = 1'b0;
        stall_b = 1'b0;
      end
    end
  end

  // Present one vector and keep it until accepted; returns at posedge+1.
  task automatic send(input logic [7:0] v, input logic [2:0] l);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    s_vect = v;
    s_lim  = l;
    s_vld  = 1'b1;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = a_srdy;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'(1));
  endtask

  // Single transaction through an empty pipeline, exact latency checked.
  task automatic dir(input string name, input logic [7:0] v, input logic [2:0] l,
                     input logic [31:0] exp_a, input logic [31:0] exp_b,
                     input logic [2:0] ecnt, input logic eovf);
    m_rdy  = 1'b1;
    s_vect = v;
    s_lim  = l;
    s_vld  = 1'b1;
    @(negedge clk);
    chk({name, "_srdy"}, 64'(a_srdy), 64'(1));
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    @(negedge clk);
    chk({name, "_early_vld"}, 64'(a_mvld), 64'(0));
    @(negedge clk);
    chk({name, "_a_vld"}, 64'(a_mvld), 64'(1));
    chk({name, "_a_oh"}, 64'(a_oh), 64'(exp_a));
    chk({name, "_a_cnt"}, 64'(a_cnt), 64'(ecnt));
    chk({name, "_a_ovf"}, 64'(a_ovf), 64'(eovf));
    chk({name, "_b_vld"}, 64'(b_mvld), 64'(1));
    chk({name, "_b_oh"}, 64'(b_oh), 64'(exp_b));
    chk({name, "_b_cnt"}, 64'(b_cnt), 64'(ecnt));
    chk({name, "_b_ovf"}, 64'(b_ovf), 64'(eovf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_vld", 64'(a_mvld), 64'(0));
    chk("rst_a_oh", 64'(a_oh), 64'(0));
    chk("rst_a_cnt", 64'(a_cnt), 64'(0));
    chk("rst_a_ovf", 64'(a_ovf), 64'(0));
    chk("rst_b_vld", 64'(b_mvld), 64'(0));
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_a_srdy", 64'(a_srdy), 64'(1));
    chk("rst_b_srdy", 64'(b_srdy), 64'(1));
    @(posedge clk);
    #1;

    // Directed cases: LSB-first expectations on A, MSB-first on B
    dir("lsb_a6", 8'hA6, 3'd4, 32'h80200402, 32'h02042080, 3'd4, 1'b0);
    dir("all_ff", 8'hFF, 3'd4, 32'h08040201, 32'h10204080, 3'd4, 1'b1);
    dir("lim_sat", 8'hFF, 3'd7, 32'h08040201, 32'h10204080, 3'd4, 1'b1);
    dir("lim1", 8'h06, 3'd1, 32'h00000002, 32'h00000004, 3'd1, 1'b1);
    dir("zero", 8'h00, 3'd4, 32'h00000000, 32'h00000000, 3'd0, 1'b0);
    dir("lim0", 8'h30, 3'd0, 32'h00000000, 32'h00000000, 3'd0, 1'b1);

    // Backpressure: four pushes, output stalled for four cycles
    pop_cyc.delete();
    sb_en = 1'b1;
    m_rdy = 1'b0;
    send(8'h01, 3'd4);
    send(8'h03, 3'd4);
    s_vect = 8'h07;
    s_lim  = 3'd4;
    s_vld  = 1'b1;
    @(negedge clk);
    chk("bp_srdy_low", 64'(a_srdy), 64'(0));
    chk("bp_mvld", 64'(a_mvld), 64'(1));
    chk("bp_head", 64'(a_oh), 64'(32'h00000001));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_srdy_still_low", 64'(a_srdy), 64'(0));
    chk("bp_head_held", 64'(a_oh), 64'(32'h00000001));
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    send(8'h07, 3'd4);
    send(8'h0F, 3'd4);
    s_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_pops", 64'(pop_cyc.size()), 64'(4));
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("bp_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(1));
    end
    chk("bp_a_empty", 64'(qa.size()), 64'(0));
    sb_en = 1'b0;

    // Reset with two transactions in flight
    m_rdy = 1'b0;
    send(8'h55, 3'd4);
    send(8'h0F, 3'd2);
    s_vld = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    chk("rstmid_a_vld", 64'(a_mvld), 64'(0));
    chk("rstmid_b_vld", 64'(b_mvld), 64'(0));
    chk("rstmid_a_oh", 64'(a_oh), 64'(0));
    chk("rstmid_a_cnt", 64'(a_cnt), 64'(0));
    chk("rstmid_a_ovf", 64'(a_ovf), 64'(0));
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    qa.delete();
    qb.delete();
    sb_en = 1'b1;
    m_rdy = 1'b1;
    @(negedge clk);
    chk("rstrel_a_srdy", 64'(a_srdy), 64'(1));
    repeat (6) @(posedge clk);
    #1;
    chk("rstrel_a_vld", 64'(a_mvld), 64'(0));

    // Random traffic with random backpressure
    for (int c = 0; c < 4000; c++) begin
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = v & $urandom;
      s_vect = v[7:0];
      s_lim  = 3'($urandom_range(0, 7));
      s_vld  = ($urandom_range(0, 3) != 0);
      m_rdy  = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    s_vld = 1'b0;
    m_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_a_drain", 64'(qa.size()), 64'(0));
    chk("rand_b_drain", 64'(qb.size()), 64'(0));
    sb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
